// File: rtl/ml_acc_pkg.sv
// ============================================================================
// Module      : ml_acc_pkg
// Description : Shared types and constants for the accelerator memory path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ml_acc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int MEM_RD_LATENCY = 1;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request at or
//               above the pointer, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  always_comb begin
    int w_pos;
    w_pos   = 0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!o_found && i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = IW'(w_pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ml_mem_arbiter.sv
// ============================================================================
// Module      : ml_mem_arbiter
// Description : Round-robin, burst-locking arbiter sharing one external
//               memory port; optional per-requester beat counters under
//               ML_MEM_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ml_mem_arbiter
  import ml_acc_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic [ADDR_W-1:0]           ext_mem_addr,
  output logic [DATA_W-1:0]           ext_mem_data_out,
  output logic                        ext_mem_we,
  output logic                        ext_mem_re,
  input  logic [DATA_W-1:0]           ext_mem_data_in,
  input  logic                        ext_mem_ready
`ifdef ML_MEM_ARB_PERF_EN
  ,
  input  logic                        perf_clr,
  output logic [NUM_REQ*32-1:0]       perf_beats
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST);

  arb_state_t     r_state;
  logic [IW-1:0]  r_grant;
  logic [IW-1:0]  r_ptr;
  logic [IW-1:0]  r_rd_tag;
  logic [CW-1:0]  r_beat_cnt;
  logic           r_busy;
  logic           r_rd_pend;

  logic [IW-1:0]  w_pick_idx;
  logic           w_pick_found;
  logic           w_in_grant;
  logic           w_valid_g;
  logic           w_we_g;
  logic           w_accept;
  logic           w_done;
  logic [IW-1:0]  w_next_ptr;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_in_grant = (r_state == GRANT);
  assign w_valid_g  = w_in_grant & req_valid[r_grant];
  assign w_we_g     = req_we[r_grant];
  assign w_accept   = w_valid_g & ext_mem_ready;
  assign w_done     = w_accept & (req_last[r_grant] | (r_beat_cnt == CW'(MAX_BURST - 1)));
  assign w_next_ptr = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + IW'(1);

  // Address/data are zeroed outside GRANT so the bus is quiet while idle.
  assign ext_mem_re       = w_valid_g & ~w_we_g;
  assign ext_mem_we       = w_valid_g & w_we_g;
  assign ext_mem_addr     = w_in_grant ? req_addr[r_grant*ADDR_W +: ADDR_W] : '0;
  assign ext_mem_data_out = w_in_grant ? req_wdata[r_grant*DATA_W +: DATA_W] : '0;
  assign rsp_data         = r_rd_pend ? ext_mem_data_in : '0;
  assign grant_id         = r_grant;
  assign busy             = r_busy;

  always_comb begin
    req_ready = '0;
    if (w_in_grant) req_ready[r_grant] = ext_mem_ready;
  end

  always_comb begin
    rsp_valid = '0;
    if (r_rd_pend) rsp_valid[r_rd_tag] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_rd_tag   <= '0;
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
      r_rd_pend  <= 1'b0;
    end else begin
      // Read return runs beside the FSM so the last response lands in RELEASE.
      r_rd_pend <= w_accept & ~w_we_g;
      r_rd_tag  <= r_grant;
      case (r_state)
        IDLE: begin
          if (w_pick_found) begin
            r_grant    <= w_pick_idx;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (w_accept) r_beat_cnt <= r_beat_cnt + CW'(1);
          if (w_done) begin
            r_busy  <= 1'b0;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_ptr   <= w_next_ptr;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ML_MEM_ARB_PERF_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
      logic [31:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (perf_clr) begin
          r_cnt <= '0;
        end else if (w_accept && (r_grant == IW'(gi)) && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
      assign perf_beats[gi*32 +: 32] = r_cnt;
    end
  endgenerate
`endif

endmodule

`default_nettype wire
